// File: rtl/interleave_scheduler.sv
// interleave_scheduler: round-robin arbiter that shares one interleaver input
// port between NUM_REQ channel-group producers. A grant lasts up to BURST_LEN
// beats (or until the producer flags req_last_i), beats are counted against a
// per-frame total latched at start, and frame_done_o pulses when it is reached.
//
// Optional build macro INTERLEAVE_SCHED_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of XFER cycles where a beat was offered but not accepted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; frame counters parked
// ARB    | one bubble cycle per grant; round-robin search from ptr
// XFER   | granted producer passes straight through to the interleaver
// DONE   | one-cycle frame_done_o pulse, then back to IDLE
module interleave_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_REQ      = 4,
    parameter int BURST_LEN    = 8,
    parameter int FRAME_W      = 20,
    localparam int W           = DATA_WIDTH * NUM_CHANNELS,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [FRAME_W-1:0]     cfg_frame_beats_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [W-1:0]           out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [GW-1:0]          out_grp_o,
    output logic                   busy_o,
    output logic                   frame_done_o
`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt_o
`endif
);

    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef logic [GW:0] cand_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        gnt_q, gnt_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0]   frame_beats_q, frame_beats_d;
    logic [W-1:0]         data_hold_q, data_hold_d;

    logic [W-1:0]         req_beat [NUM_REQ];
    logic [W-1:0]         gnt_data;
    logic                 gnt_valid;
    logic                 gnt_last;
    logic                 in_xfer;
    logic                 beat_fire;
    logic                 start_accept;
    logic [BW-1:0]        burst_cnt_inc;
    logic [FRAME_W-1:0]   frame_cnt_inc;
    logic                 frame_end;
    logic                 burst_end;
    logic                 arb_hit;
    logic [GW-1:0]        arb_win;
    logic [GW-1:0]        arb_next_ptr;
    cand_t                cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
        assign req_beat[g] = req_data_i[g*W +: W];
    end

    assign gnt_data      = req_beat[gnt_q];
    assign gnt_valid     = req_valid_i[gnt_q];
    assign gnt_last      = req_last_i[gnt_q];
    assign in_xfer       = (state_q == S_XFER);
    assign beat_fire     = in_xfer && gnt_valid && out_ready_i;
    assign burst_cnt_inc = burst_cnt_q + BW'(1);
    assign frame_cnt_inc = frame_cnt_q + FRAME_W'(1);
    assign frame_end     = (frame_cnt_inc == frame_beats_q);
    assign burst_end     = (burst_cnt_inc == BW'(BURST_LEN));
    assign arb_next_ptr  = (arb_win == GW'(NUM_REQ - 1)) ? '0 : arb_win + GW'(1);

    // Round-robin search: walk offsets from the far end so the requester
    // closest to ptr (offset 0 first) is the last, and therefore winning, hit.
    always_comb begin
        arb_hit = 1'b0;
        arb_win = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + cand_t'(i);
            if (cand >= cand_t'(NUM_REQ)) begin
                cand = cand - cand_t'(NUM_REQ);
            end
            if (req_valid_i[cand[GW-1:0]]) begin
                arb_hit = 1'b1;
                arb_win = cand[GW-1:0];
            end
        end
    end

    // Next-state and counter update for the frame/burst sequencer.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        burst_cnt_d   = burst_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_beats_d = frame_beats_q;
        data_hold_d   = data_hold_q;
        start_accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_accept  = 1'b1;
                    frame_beats_d = cfg_frame_beats_i;
                    frame_cnt_d   = '0;
                    state_d       = (cfg_frame_beats_i == '0) ? S_DONE : S_ARB;
                end
            end
            S_ARB: begin
                if (arb_hit) begin
                    gnt_d       = arb_win;
                    burst_cnt_d = '0;
                    ptr_d       = arb_next_ptr;
                    state_d     = S_XFER;
                end
            end
            S_XFER: begin
                // Track what is on the bus so out_data_o holds it after XFER.
                data_hold_d = gnt_data;
                if (beat_fire) begin
                    burst_cnt_d = burst_cnt_inc;
                    frame_cnt_d = frame_cnt_inc;
                    if (frame_end) begin
                        state_d = S_DONE;
                    end else if (gnt_last || burst_end) begin
                        state_d = S_ARB;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Zero-latency pass-through of the granted producer; idle outputs hold.
    always_comb begin
        req_ready_o = '0;
        if (in_xfer) begin
            req_ready_o[gnt_q] = out_ready_i;
        end
        out_valid_o  = in_xfer && gnt_valid;
        out_data_o   = in_xfer ? gnt_data : data_hold_q;
        out_grp_o    = gnt_q;
        busy_o       = (state_q == S_ARB) || (state_q == S_XFER);
        frame_done_o = (state_q == S_DONE);
    end

    // Sequencer registers; reset drops any in-flight beat and all frame state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            burst_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            frame_beats_q <= '0;
            data_hold_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            burst_cnt_q   <= burst_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_beats_q <= frame_beats_d;
            data_hold_q   <= data_hold_d;
        end
    end

`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of back-pressured XFER cycles; kept after DONE for readout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if (in_xfer && gnt_valid && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_interleave_scheduler.sv
// Directed bench for interleave_scheduler. The bench plays all producers:
// requester g emits beat_val(g, s) for its s-th beat, so every logged beat can
// be checked for source, order and content against hand-derived sequences.
module tb_interleave_scheduler;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int NR = 4;
    localparam int BL = 8;
    localparam int FW = 20;
    localparam int W  = DW * NC;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [FW-1:0]     cfg_frame_beats_i = '0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR*W-1:0]   req_data_i = '0;
    logic [NR-1:0]     req_last_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [W-1:0]      out_data_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [1:0]        out_grp_o;
    logic              busy_o;
    logic              frame_done_o;
`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
    logic [15:0]       stall_cnt_o;
`endif

    interleave_scheduler #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NC),
        .NUM_REQ      (NR),
        .BURST_LEN    (BL),
        .FRAME_W      (FW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .cfg_frame_beats_i (cfg_frame_beats_i),
        .req_valid_i       (req_valid_i),
        .req_data_i        (req_data_i),
        .req_last_i        (req_last_i),
        .req_ready_o       (req_ready_o),
        .out_data_o        (out_data_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_grp_o         (out_grp_o),
        .busy_o            (busy_o),
        .frame_done_o      (frame_done_o)
`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o       (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // producer model and observation logs
    int            seq [NR];
    int            last_seq [NR];
    logic [NR-1:0] valid_mask;
    bit            ready_toggle;
    bit            start_drv;
    logic [FW-1:0] cfg_drv;
    int            cyc;
    int            done_cnt;
    int            done_cyc;
    bit            ready_seen;
    int            log_grp [$];
    logic [W-1:0]  log_data [$];
    int            log_cyc [$];
    bit            busy_log [$];

    function automatic logic [W-1:0] beat_val(input int g, input int s);
        logic [15:0] gg;
        logic [15:0] ss;
        gg = 16'(g);
        ss = 16'(s);
        return {16'h5A00 | gg, ss, ss + (gg << 8), ~ss};
    endfunction

    task automatic clear_log();
        for (int i = 0; i < NR; i++) begin
            seq[i]      = 0;
            last_seq[i] = -1;
        end
        log_grp.delete();
        log_data.delete();
        log_cyc.delete();
        busy_log.delete();
        cyc          = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        ready_seen   = 1'b0;
        ready_toggle = 1'b0;
        start_drv    = 1'b0;
    endtask

    // One clock: drive at posedge+1, observe at posedge+2, end at next posedge+1.
    task automatic step();
        start_i           = start_drv;
        cfg_frame_beats_i = cfg_drv;
        req_valid_i       = valid_mask;
        for (int i = 0; i < NR; i++) begin
            req_data_i[i*W +: W] = beat_val(i, seq[i]);
            req_last_i[i]        = (seq[i] == last_seq[i]);
        end
        out_ready_i = ready_toggle ? (cyc % 2 == 0) : 1'b1;
        #1;
        busy_log.push_back(busy_o);
        if (frame_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (req_ready_o != '0) ready_seen = 1'b1;
        if (out_valid_o && out_ready_i) begin
            log_grp.push_back(int'(out_grp_o));
            log_data.push_back(out_data_o);
            log_cyc.push_back(cyc);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) seq[i]++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input logic [FW-1:0] cfg, input int max_cyc, output bit timed_out);
        cfg_drv   = cfg;
        start_drv = 1'b1;
        step();
        start_drv = 1'b0;
        timed_out = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            step();
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) step();
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        start_i     = 1'b0;
        req_valid_i = '0;
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Compare logged beat k against (grp, seq).
    task automatic check_beat(input string name, input int k, input int eg, input int es);
        checks++;
        if (k >= log_grp.size()) begin
            errors++;
            $display("FAIL %s beat %0d: missing, required grp=%0d seq=%0d", name, k, eg, es);
        end else if (log_grp[k] !== eg || log_data[k] !== beat_val(eg, es)) begin
            errors++;
            $display("FAIL %s beat %0d: got grp=%0d data=%h, required grp=%0d data=%h",
                     name, k, log_grp[k], log_data[k], eg, beat_val(eg, es));
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b done=%b, required all 0",
                     out_valid_o, req_ready_o, busy_o, frame_done_o);
        end
        checks++;
        if (out_grp_o !== 2'd0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got grp=%0d data=%h, required 0/0", out_grp_o, out_data_o);
        end
`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d, required 0", stall_cnt_o);
        end
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_all_valid();
        bit to;
        int last;
        clear_log();
        valid_mask = 4'b1111;
        run_frame(20'd64, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL all_valid_timeout: no frame_done within 200 cycles"); end
        checks++;
        if (log_grp.size() != 64) begin
            errors++;
            $display("FAIL all_valid_count: got %0d beats, required 64", log_grp.size());
        end
        for (int k = 0; k < 64; k++) check_beat("all_valid", k, (k / 8) % 4, (k / 32) * 8 + k % 8);
        checks++;
        if (log_cyc.size() == 0 || log_cyc[0] != 2) begin
            errors++;
            $display("FAIL all_valid_first: got first beat cycle %0d, required 2",
                     log_cyc.size() ? log_cyc[0] : -1);
        end
        for (int k = 1; k < 64 && k < log_cyc.size(); k++) begin
            checks++;
            if (log_cyc[k] - log_cyc[k-1] != ((k % 8 == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL all_valid_gap beat %0d: got gap %0d, required %0d",
                         k, log_cyc[k] - log_cyc[k-1], (k % 8 == 0) ? 2 : 1);
            end
        end
        last = log_cyc.size() ? log_cyc[log_cyc.size()-1] : -10;
        checks++;
        if (done_cnt != 1 || done_cyc != last + 1 || done_cyc != 73) begin
            errors++;
            $display("FAIL all_valid_done: got pulses=%0d at cycle %0d, required 1 at 73", done_cnt, done_cyc);
        end
        checks++;
        if (done_cyc < 1 || done_cyc >= busy_log.size() || busy_log[done_cyc] !== 1'b0 || busy_log[done_cyc-1] !== 1'b1) begin
            errors++;
            $display("FAIL all_valid_busy: busy did not fall on the frame_done cycle %0d", done_cyc);
        end
    endtask

    task automatic test_single_req();
        bit to;
        int last;
        clear_log();
        valid_mask = 4'b0100;
        run_frame(20'd20, 100, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: no frame_done within 100 cycles"); end
        checks++;
        if (log_grp.size() != 20) begin
            errors++;
            $display("FAIL single_count: got %0d beats, required 20", log_grp.size());
        end
        for (int k = 0; k < 20; k++) check_beat("single", k, 2, k);
        for (int k = 1; k < 20 && k < log_cyc.size(); k++) begin
            checks++;
            if (log_cyc[k] - log_cyc[k-1] != ((k == 8 || k == 16) ? 2 : 1)) begin
                errors++;
                $display("FAIL single_gap beat %0d: got gap %0d, required %0d",
                         k, log_cyc[k] - log_cyc[k-1], (k == 8 || k == 16) ? 2 : 1);
            end
        end
        last = log_cyc.size() ? log_cyc[log_cyc.size()-1] : -10;
        checks++;
        if (done_cnt != 1 || done_cyc != last + 1 || done_cyc != 24) begin
            errors++;
            $display("FAIL single_done: got pulses=%0d at cycle %0d, required 1 at 24", done_cnt, done_cyc);
        end
    endtask

    task automatic test_req_last();
        bit to;
        int eg [14] = '{1, 1, 1, 3, 3, 3, 3, 3, 3, 3, 3, 1, 1, 1};
        int es [14] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7, 3, 4, 5};
        do_reset();
        clear_log();
        valid_mask  = 4'b1010;
        last_seq[1] = 2;
        run_frame(20'd14, 100, to);
        checks++;
        if (to) begin errors++; $display("FAIL last_timeout: no frame_done within 100 cycles"); end
        checks++;
        if (log_grp.size() != 14) begin
            errors++;
            $display("FAIL last_count: got %0d beats, required 14", log_grp.size());
        end
        for (int k = 0; k < 14; k++) check_beat("req_last", k, eg[k], es[k]);
    endtask

    task automatic test_ready_toggle();
        bit to;
        clear_log();
        valid_mask   = 4'b0001;
        ready_toggle = 1'b1;
        run_frame(20'd6, 60, to);
        checks++;
        if (to) begin errors++; $display("FAIL toggle_timeout: no frame_done within 60 cycles"); end
        checks++;
        if (log_grp.size() != 6) begin
            errors++;
            $display("FAIL toggle_count: got %0d beats, required 6", log_grp.size());
        end
        for (int k = 0; k < 6; k++) begin
            check_beat("toggle", k, 0, k);
            checks++;
            if (k >= log_cyc.size() || log_cyc[k] != 2 + 2 * k) begin
                errors++;
                $display("FAIL toggle_cycle beat %0d: got %0d, required %0d",
                         k, (k < log_cyc.size()) ? log_cyc[k] : -1, 2 + 2 * k);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 13) begin
            errors++;
            $display("FAIL toggle_done: got pulses=%0d at cycle %0d, required 1 at 13", done_cnt, done_cyc);
        end
`ifdef INTERLEAVE_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL toggle_stall: got %0d, required 5", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_zero_frame();
        clear_log();
        valid_mask = 4'b1111;
        cfg_drv    = 20'd0;
        start_drv  = 1'b1;
        step();
        cfg_drv    = 20'd5;
        step();
        start_drv  = 1'b0;
        for (int n = 0; n < 4; n++) step();
        checks++;
        if (done_cnt != 1 || done_cyc != 1) begin
            errors++;
            $display("FAIL zero_done: got pulses=%0d at cycle %0d, required 1 at 1", done_cnt, done_cyc);
        end
        checks++;
        if (ready_seen || log_grp.size() != 0) begin
            errors++;
            $display("FAIL zero_ready: got ready_seen=%0d beats=%0d, required 0/0", ready_seen, log_grp.size());
        end
        checks++;
        if (busy_log[1] !== 1'b0 || busy_log[2] !== 1'b0 || busy_log[3] !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: got busy=%b%b%b on cycles 1..3, required 000",
                     busy_log[1], busy_log[2], busy_log[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        do_reset();
        clear_log();
        valid_mask = 4'b1111;
        cfg_drv    = 20'd64;
        start_drv  = 1'b1;
        step();
        start_drv  = 1'b0;
        for (int n = 0; n < 30 && log_grp.size() < 5; n++) step();
        checks++;
        if (log_grp.size() != 5) begin
            errors++;
            $display("FAIL midrst_setup: got %0d beats, required 5", log_grp.size());
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got valid=%b ready=%b busy=%b done=%b, required all 0",
                     out_valid_o, req_ready_o, busy_o, frame_done_o);
        end
        checks++;
        if (out_grp_o !== 2'd0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL midrst_data: got grp=%0d data=%h, required 0/0", out_grp_o, out_data_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        clear_log();
        valid_mask = 4'b1111;
        run_frame(20'd2, 30, to);
        checks++;
        if (to || log_grp.size() != 2) begin
            errors++;
            $display("FAIL midrst_refrm: got timeout=%0d beats=%0d, required 0/2", to, log_grp.size());
        end
        check_beat("midrst", 0, 0, 0);
        check_beat("midrst", 1, 0, 1);
        checks++;
        if (log_cyc.size() == 0 || log_cyc[0] != 2) begin
            errors++;
            $display("FAIL midrst_first: got first beat cycle %0d, required 2",
                     log_cyc.size() ? log_cyc[0] : -1);
        end
    endtask

    initial begin
        valid_mask = '0;
        cfg_drv    = '0;
        clear_log();
        #1;
        test_reset();
        test_all_valid();
        test_single_req();
        test_req_last();
        test_ready_toggle();
        test_zero_frame();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
